// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// load_store_unit_pkg : access-size constants and LSU state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  localparam logic [3:0] RW_BYTE     = 4'h0;
  localparam logic [3:0] RW_HALFWORD = 4'h1;
  localparam logic [3:0] RW_WORD     = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_REQ2  = 3'd4,
    S_WAIT2 = 3'd5
  } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// lsu_align : byte enables, store lane steering, load extension, misalign check
// Revision 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [3:0]  rw_mode,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata_ext,
  output logic        illegal,
  output logic        misaligned
);

  logic [3:0]  pattern;
  logic [7:0]  be8;
  logic [31:0] wrep;
  logic [31:0] rsh;
  logic [63:0] w64;

  always_comb begin
    pattern = 4'b0000;
    wrep    = wdata;
    illegal = 1'b0;
    case (rw_mode)
      RW_BYTE: begin
        pattern = 4'b0001;
        wrep    = {4{wdata[7:0]}};
      end
      RW_HALFWORD: begin
        pattern = 4'b0011;
        wrep    = {2{wdata[15:0]}};
      end
      RW_WORD: pattern = 4'b1111;
      default: illegal = 1'b1;
    endcase

    misaligned = ((rw_mode == RW_HALFWORD) && offset[0]) ||
                 ((rw_mode == RW_WORD) && (offset != 2'b00));

    // The access is viewed as an 8-byte window so a split access falls out
    // of the same shifts; aligned accesses never touch the high word.
    be8      = {4'b0000, pattern} << offset;
    be_lo    = be8[3:0];
    be_hi    = be8[7:4];
    w64      = {32'b0, wdata} << {offset, 3'b000};
    wdata_lo = misaligned ? w64[31:0] : wrep;
    wdata_hi = w64[63:32];

    rsh = 32'({rdata_hi, rdata_lo} >> {offset, 3'b000});
    case (rw_mode)
      RW_BYTE:     rdata_ext = is_unsigned ? {24'b0, rsh[7:0]}
                                           : {{24{rsh[7]}}, rsh[7:0]};
      RW_HALFWORD: rdata_ext = is_unsigned ? {16'b0, rsh[15:0]}
                                           : {{16{rsh[15]}}, rsh[15:0]};
      default:     rdata_ext = rsh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : single-outstanding load/store responder to a word memory.
// Optional macro LSU_MISALIGNED_SPLIT_EN splits misaligned accesses. Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic              core_we,
  input  logic [3:0]        core_rw_mode,
  input  logic              core_unsigned,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e state, state_next;

  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        mode_r;
  logic              we_r, uns_r, err_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;

  logic        idle, reject;
  logic [3:0]  be_lo, be_hi;
  logic [31:0] wd_lo, wd_hi, rd_lo, rd_hi, rd_ext;
  logic        illegal, misaligned;

  assign idle = (state == S_IDLE);

  // In IDLE the aligner checks the incoming request; afterwards it works
  // from the registered copy so the memory port stays stable.
  lsu_align u_align (
    .rw_mode     (idle ? core_rw_mode  : mode_r),
    .is_unsigned (idle ? core_unsigned : uns_r),
    .offset      (idle ? core_addr[1:0] : addr_r[1:0]),
    .wdata       (idle ? core_wdata    : wdata_r),
    .rdata_lo    (rd_lo),
    .rdata_hi    (rd_hi),
    .be_lo       (be_lo),
    .be_hi       (be_hi),
    .wdata_lo    (wd_lo),
    .wdata_hi    (wd_hi),
    .rdata_ext   (rd_ext),
    .illegal     (illegal),
    .misaligned  (misaligned)
  );

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_r;
  logic [31:0] rdata_lo_r;
  assign rd_lo  = (state == S_WAIT2) ? rdata_lo_r : mem_rdata;
  assign rd_hi  = (state == S_WAIT2) ? mem_rdata : 32'b0;
  assign reject = illegal;
`else
  logic unused_split;
  assign unused_split = ^{be_hi, wd_hi};
  assign rd_lo  = mem_rdata;
  assign rd_hi  = 32'b0;
  assign reject = illegal | misaligned;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_r  <= '0;
      mode_r  <= 4'b0;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      err_r   <= 1'b0;
      wdata_r <= '0;
      rdata_r <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_r    <= 1'b0;
      rdata_lo_r <= 32'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (core_valid) begin
          addr_r  <= core_addr;
          mode_r  <= core_rw_mode;
          we_r    <= core_we;
          uns_r   <= core_unsigned;
          wdata_r <= core_wdata;
          err_r   <= reject;
`ifdef LSU_MISALIGNED_SPLIT_EN
          split_r <= misaligned & ~illegal;
`endif
        end
        S_WAIT: if (mem_rvalid && !we_r) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_r) rdata_lo_r <= mem_rdata;
          else         rdata_r    <= rd_ext;
`else
          rdata_r <= rd_ext;
`endif
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        S_WAIT2: if (mem_rvalid) rdata_r <= rd_ext;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (core_valid) state_next = reject ? S_RESP : S_REQ;
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ:  if (mem_gnt) state_next = (we_r && !split_r) ? S_RESP : S_WAIT;
      // Split stores pass through WAIT as a turnaround before the 2nd word.
      S_WAIT: begin
        if (we_r)            state_next = S_REQ2;
        else if (mem_rvalid) state_next = split_r ? S_REQ2 : S_RESP;
      end
      S_REQ2:  if (mem_gnt) state_next = we_r ? S_RESP : S_WAIT2;
      S_WAIT2: if (mem_rvalid) state_next = S_RESP;
`else
      S_REQ:  if (mem_gnt) state_next = we_r ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid) state_next = S_RESP;
`endif
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    core_ready  = idle;
    core_rvalid = (state == S_RESP);
    core_err    = (state == S_RESP) && err_r;
    core_rdata  = ((state == S_RESP) && (we_r || err_r)) ? '0 : rdata_r;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (state == S_REQ) begin
      mem_req   = 1'b1;
      mem_we    = we_r;
      mem_be    = be_lo;
      mem_addr  = {addr_r[ADDR_W-1:2], 2'b00};
      mem_wdata = we_r ? wd_lo : '0;
    end
`ifdef LSU_MISALIGNED_SPLIT_EN
    if (state == S_REQ2) begin
      mem_req   = 1'b1;
      mem_we    = we_r;
      mem_be    = be_hi;
      mem_addr  = {addr_r[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
      mem_wdata = we_r ? wd_hi : '0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed + randomized checks against a byte-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;
  import load_store_unit_pkg::*;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_valid, core_ready, core_we, core_unsigned;
  logic [3:0]  core_rw_mode;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_rvalid, core_err;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
    .core_rw_mode(core_rw_mode), .core_unsigned(core_unsigned),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] dut_mem [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  int          obs_lat, obs_pulses, obs_nreq, obs_unstable;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [31:0] req_addr [2];
  logic [3:0]  req_be   [2];
  logic        req_we   [2];
  logic [31:0] req_wdata[2];

  // ---------------- byte-level reference model ----------------
  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  function automatic logic [31:0] dut_word(input logic [31:0] wa);
    return dut_mem.exists(wa) ? dut_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic void ref_put_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_word({a[31:2], 2'b00});
    w[8*a[1:0] +: 8] = b;
    ref_mem[{a[31:2], 2'b00}] = w;
  endfunction

  function automatic int size_of(input logic [3:0] mode);
    case (mode)
      RW_BYTE:     return 1;
      RW_HALFWORD: return 2;
      RW_WORD:     return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [3:0] mode, input logic [31:0] a);
    int n;
    n = size_of(mode);
    return (n > 1) && ((a % n) != 0);
  endfunction

  function automatic bit ref_err(input logic [3:0] mode, input logic [31:0] a);
    return (size_of(mode) == 0) || (ref_mis(mode, a) && !SPLIT);
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] mode, input logic uns,
                                           input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'b0;
    n = size_of(mode);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + i);
    if (n == 1 && !uns && v[7])  v[31:8]  = '1;
    if (n == 2 && !uns && v[15]) v[31:16] = '1;
    return v;
  endfunction

  function automatic void ref_store(input logic [3:0] mode, input logic [31:0] a,
                                    input logic [31:0] d);
    for (int i = 0; i < size_of(mode); i++) ref_put_byte(a + i, d[8*i +: 8]);
  endfunction

  function automatic int ref_lat(input logic we, input logic [3:0] mode,
                                 input logic [31:0] a, input int gd);
    if (ref_err(mode, a)) return 1;
    if (ref_mis(mode, a)) return we ? 4 + 2*gd : 5 + 2*gd;
    return we ? 2 + gd : 3 + gd;
  endfunction

  function automatic void set_word(input logic [31:0] wa, input logic [31:0] d);
    dut_mem[wa] = d;
    ref_mem[wa] = d;
  endfunction

  // ---------------- driver + memory responder ----------------
  task automatic run_op(input logic we, input logic [3:0] mode, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int gd);
    int          waited;
    bit          have, pend;
    logic [68:0] snap;
    logic [31:0] pdata, w;
    obs_lat = -1; obs_pulses = 0; obs_nreq = 0; obs_unstable = 0;
    obs_rdata = 32'hX; obs_err = 1'bX;
    have = 0; pend = 0; waited = 0; pdata = 0;
    @(negedge clk);
    core_valid = 1'b1; core_we = we; core_rw_mode = mode;
    core_unsigned = uns; core_addr = addr; core_wdata = wdata;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      core_valid = 1'b0;
      core_wdata = $urandom;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pdata;
        pend = 0;
      end
      if (mem_req) begin
        if (!have) begin
          snap = {mem_addr, mem_be, mem_we, mem_wdata};
          have = 1; waited = 0;
          if (obs_nreq < 2) begin
            req_addr[obs_nreq] = mem_addr; req_be[obs_nreq] = mem_be;
            req_we[obs_nreq] = mem_we;     req_wdata[obs_nreq] = mem_wdata;
          end
          obs_nreq++;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== snap) begin
          obs_unstable++;
        end
        if (waited >= gd) begin
          mem_gnt = 1'b1;
          have = 0;
          if (mem_we) begin
            w = dut_word(mem_addr);
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            dut_mem[mem_addr] = w;
          end else begin
            pend  = 1;
            pdata = dut_word(mem_addr);
          end
        end
        waited++;
      end
      if (core_rvalid) begin
        obs_pulses++;
        if (obs_lat < 0) begin
          obs_lat = k; obs_rdata = core_rdata; obs_err = core_err;
        end
      end
      if (obs_lat >= 0 && k >= obs_lat + 2) break;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({core_ready, core_rvalid, core_err, core_rdata} !== {1'b1, 1'b0, 1'b0, 32'b0}) begin
      errors++;
      $display("FAIL reset_core: got ready=%b rvalid=%b err=%b rdata=%h, want 1 0 0 0",
               core_ready, core_rvalid, core_err, core_rdata);
    end
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got req=%b we=%b be=%b addr=%h wdata=%h, want all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (core_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", core_ready);
    end
  endtask

  task automatic test_store_word();
    run_op(1'b1, RW_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    ref_store(RW_WORD, 32'h100, 32'hDEADBEEF);
    checks++;
    if (obs_lat !== 2 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_latency: got lat=%0d err=%b want lat=2 err=0", obs_lat, obs_err);
    end
    checks++;
    if ({req_addr[0], req_be[0], req_we[0], req_wdata[0]} !== {32'h100, 4'b1111, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_request: got addr=%h be=%b we=%b wdata=%h want 100 1111 1 deadbeef",
               req_addr[0], req_be[0], req_we[0], req_wdata[0]);
    end
    checks++;
    if (dut_word(32'h100) !== ref_word(32'h100)) begin
      errors++;
      $display("FAIL sw_memory: got %h want %h", dut_word(32'h100), ref_word(32'h100));
    end
  endtask

  task automatic test_store_byte();
    run_op(1'b1, RW_BYTE, 1'b0, 32'h203, 32'h000000A5, 0);
    ref_store(RW_BYTE, 32'h203, 32'h000000A5);
    checks++;
    if ({req_addr[0], req_be[0], req_wdata[0]} !== {32'h200, 4'b1000, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL sb_request: got addr=%h be=%b wdata=%h want 200 1000 a5a5a5a5",
               req_addr[0], req_be[0], req_wdata[0]);
    end
    checks++;
    if (obs_lat !== 2 || obs_rdata !== 32'b0) begin
      errors++;
      $display("FAIL sb_resp: got lat=%0d rdata=%h want lat=2 rdata=0", obs_lat, obs_rdata);
    end
  endtask

  task automatic test_load_byte();
    set_word(32'h300, 32'h123480FF);
    run_op(1'b0, RW_BYTE, 1'b0, 32'h301, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'hFFFFFF80 || obs_lat !== 3) begin
      errors++;
      $display("FAIL lb_sign: got rdata=%h lat=%0d want ffffff80 lat=3", obs_rdata, obs_lat);
    end
    checks++;
    if (req_we[0] !== 1'b0 || req_addr[0] !== 32'h300) begin
      errors++;
      $display("FAIL lb_request: got we=%b addr=%h want 0 300", req_we[0], req_addr[0]);
    end
    run_op(1'b0, RW_BYTE, 1'b1, 32'h301, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_zero: got %h want 00000080", obs_rdata);
    end
  endtask

  task automatic test_load_half_delay();
    set_word(32'h400, 32'h80010000);
    run_op(1'b0, RW_HALFWORD, 1'b0, 32'h402, 32'h0, 3);
    checks++;
    if (obs_rdata !== 32'hFFFF8001 || obs_lat !== 6) begin
      errors++;
      $display("FAIL lh_delay: got rdata=%h lat=%0d want ffff8001 lat=6", obs_rdata, obs_lat);
    end
    checks++;
    if (obs_unstable !== 0 || obs_pulses !== 1) begin
      errors++;
      $display("FAIL lh_stable_pulse: got unstable=%0d pulses=%0d want 0 1",
               obs_unstable, obs_pulses);
    end
    checks++;
    if (req_be[0] !== 4'b1100 || req_addr[0] !== 32'h400) begin
      errors++;
      $display("FAIL lh_request: got be=%b addr=%h want 1100 400", req_be[0], req_addr[0]);
    end
  endtask

  task automatic test_misaligned();
    set_word(32'h500, 32'h44332211);
    set_word(32'h504, 32'h88776655);
    run_op(1'b0, RW_WORD, 1'b0, 32'h501, 32'h0, 0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    checks++;
    if (obs_rdata !== 32'h55443322 || obs_err !== 1'b0 || obs_lat !== 5) begin
      errors++;
      $display("FAIL lw_split: got rdata=%h err=%b lat=%0d want 55443322 0 5",
               obs_rdata, obs_err, obs_lat);
    end
    checks++;
    if (obs_nreq !== 2 || req_addr[0] !== 32'h500 || req_addr[1] !== 32'h504) begin
      errors++;
      $display("FAIL lw_split_req: got n=%0d a0=%h a1=%h want 2 500 504",
               obs_nreq, req_addr[0], req_addr[1]);
    end
`else
    checks++;
    if (obs_err !== 1'b1 || obs_lat !== 1 || obs_rdata !== 32'b0) begin
      errors++;
      $display("FAIL lw_misaligned: got err=%b lat=%0d rdata=%h want 1 1 0",
               obs_err, obs_lat, obs_rdata);
    end
    checks++;
    if (obs_nreq !== 0) begin
      errors++;
      $display("FAIL lw_misaligned_noreq: got %0d requests want 0", obs_nreq);
    end
`endif
  endtask

  task automatic test_reset_midop();
    for (int v = 0; v < 2; v++) begin
      int pulses;
      @(negedge clk);
      core_valid = 1'b1; core_we = 1'b0; core_rw_mode = RW_WORD;
      core_unsigned = 1'b0; core_addr = 32'h600;
      @(negedge clk);
      core_valid = 1'b0;
      mem_gnt = (v == 1);
      @(negedge clk);
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_midop_req v%0d: got mem_req=%b want 0", v, mem_req);
      end
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (core_rvalid) pulses++;
      end
      checks++;
      if (pulses !== 0 || core_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_midop_resp v%0d: got pulses=%0d ready=%b want 0 1",
                 v, pulses, core_ready);
      end
      checks++;
      if ({core_err, core_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
        errors++;
        $display("FAIL rst_midop_outputs v%0d: got err=%b rdata=%h req=%b be=%b addr=%h want 0",
                 v, core_err, core_rdata, mem_req, mem_be, mem_addr);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic        we, uns;
      logic [3:0]  mode;
      logic [31:0] a, d, exp_rd, wa;
      int          gd, m;
      bit          e;
      we  = 1'($urandom);
      uns = 1'($urandom);
      m   = $urandom_range(0, 3);
      mode = (m == 0) ? RW_BYTE : (m == 1) ? RW_HALFWORD : (m == 2) ? RW_WORD : 4'hF;
      a   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                        : 32'h1000 + $urandom_range(0, 63);
      d   = $urandom;
      gd  = $urandom_range(0, 2);
      e   = ref_err(mode, a);
      exp_rd = (we || e) ? 32'b0 : ref_load(mode, uns, a);
      run_op(we, mode, uns, a, d, gd);
      if (we && !e) ref_store(mode, a, d);
      checks++;
      if (obs_lat !== ref_lat(we, mode, a, gd) || obs_err !== e || obs_pulses !== 1) begin
        errors++;
        $display("FAIL rand_resp #%0d: got lat=%0d err=%b pulses=%0d want lat=%0d err=%b pulses=1",
                 n, obs_lat, obs_err, obs_pulses, ref_lat(we, mode, a, gd), e);
      end
      checks++;
      if (obs_rdata !== exp_rd) begin
        errors++;
        $display("FAIL rand_rdata #%0d: got %h want %h (we=%b mode=%h addr=%h)",
                 n, obs_rdata, exp_rd, we, mode, a);
      end
      checks++;
      if (obs_nreq !== (e ? 0 : (ref_mis(mode, a) ? 2 : 1)) || obs_unstable !== 0) begin
        errors++;
        $display("FAIL rand_requests #%0d: got n=%0d unstable=%0d", n, obs_nreq, obs_unstable);
      end
      wa = {a[31:2], 2'b00};
      checks++;
      if (dut_word(wa) !== ref_word(wa) || dut_word(wa + 4) !== ref_word(wa + 4)) begin
        errors++;
        $display("FAIL rand_memory #%0d: got %h/%h want %h/%h", n,
                 dut_word(wa), dut_word(wa + 4), ref_word(wa), ref_word(wa + 4));
      end
    end
  endtask

  initial begin
    core_valid = 1'b0; core_we = 1'b0; core_rw_mode = RW_WORD; core_unsigned = 1'b0;
    core_addr = 32'b0; core_wdata = 32'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_load_half_delay();
    test_misaligned();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
